mem_arbiter: RTL

Sequencer/arbiter sharing a single unified memory port between instruction fetch (IF) and the data access issued from the EX/MEM pipeline register (read/write strobes). Sits between the pipeline and memory. It issues at most one memory transaction at a time, data before instruction. It freezes the pipeline through `stall` until every access requested in the current pipeline cycle has completed.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arb_timer.sv | 30 +++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    D_WAIT  = 2'd1,
    I_WAIT  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int unsigned MEM_ARB_TIMEOUT = 64;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter.
// master: the arbiter; slave: pipeline plus memory environment.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_read;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              timeout_err;

  modport master (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, dm_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );

  modport slave (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, dm_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );
endinterface

// File: rtl/mem_arb_timer.sv
// Per-transaction wait counter; expired pulses on the wait cycle that brings
// the count to TIMEOUT. Only used when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_ARB_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign expired = run & (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and EX/MEM data access,
// data first, stalling the pipeline until all requested accesses complete.
// Optional per-transaction timeout: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = MEM_ARB_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);
  arb_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              dm_req, any_req, ack, waiting, issue, expired;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be at least 1");
  end

  assign dm_req  = bus.dm_read | bus.dm_write;
  assign any_req = dm_req | bus.if_req;
  assign ack     = bus.mem_ack & mem_req_q;
  assign waiting = (state_q == D_WAIT) || (state_q == I_WAIT);

  assign bus.stall     = any_req & (state_q != RELEASE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    issue       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dm_req) begin
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          mem_we_d    = bus.dm_write;
          mem_req_d   = 1'b1;
          issue       = 1'b1;
          state_d     = D_WAIT;
        end else if (bus.if_req) begin
          mem_addr_d = bus.if_addr;
          mem_we_d   = 1'b0;
          mem_req_d  = 1'b1;
          issue      = 1'b1;
          state_d    = I_WAIT;
        end
      end
      D_WAIT: begin
        if (ack) begin
          if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
          // Chain the pending fetch on the same edge to avoid an idle bubble.
          if (bus.if_req) begin
            mem_addr_d = bus.if_addr;
            mem_we_d   = 1'b0;
            issue      = 1'b1;
            state_d    = I_WAIT;
          end else begin
            mem_req_d = 1'b0;
            state_d   = RELEASE;
          end
        end else if (expired) begin
          mem_req_d = 1'b0;
          state_d   = RELEASE;
        end
      end
      I_WAIT: begin
        if (ack) begin
          if_rdata_d = bus.mem_rdata;
          mem_req_d  = 1'b0;
          state_d    = RELEASE;
        end else if (expired) begin
          mem_req_d = 1'b0;
          state_d   = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic tmo_err_q;

  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (issue),
    .run    (waiting & ~ack),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_err_q <= 1'b0;
    end else if (expired) begin
      tmo_err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = tmo_err_q;
`else
  logic unused_wait;
  assign unused_wait     = waiting | issue;
  assign expired         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

endmodule
